// File: rtl/ptw_axi_reader.sv
// ptw_axi_reader
// Fetches one page-table entry for the TLB walker over a single-beat AXI read.
// Only one request is outstanding at a time. FLUSH abandons the walk. The AXI
// transaction still finishes, but its data is thrown away.
//
// Optional feature: define PTW_LAST_PTE_CACHE_EN to add a one-entry cache of
// the last good PTE. A request to the same 8-byte line then gets its answer in
// one cycle, with no bus traffic.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   REQ_VALID/ADDR  one-cycle request pulse and PTE physical address
//   FLUSH           abort the in-flight walk and invalidate the cache
//   RESP_VALID      one-cycle response pulse
//   RESP_DATA/ERR   returned PTE (zero on error) and bus-error flag
//   BUSY            a walk is in flight
//   AR*/R*          AXI read address and read data channels
module ptw_axi_reader #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic                  FLUSH,
  output logic                  RESP_VALID,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  RESP_ERR,
  output logic                  BUSY,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [3:0]            ARID,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic [3:0]            RID
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state;
  logic   drop;        // walk was flushed; consume R beat silently
  logic   resp_pulse;  // registered response strobe, gated by FLUSH below
  logic   cache_hit;

  // Every request is a single 8-byte INCR beat with a fixed ID.
  assign ARID    = 4'(AXI_ID);
  assign ARLEN   = 8'd0;
  assign ARSIZE  = 3'd3;
  assign ARBURST = 2'b01;

  // A FLUSH that arrives during the response cycle must still cancel it.
  assign RESP_VALID = resp_pulse & ~FLUSH;

  // Single beat and single ID, so RLAST and RID carry no information.
  logic unused_ok;
  assign unused_ok = ^{RLAST, RID, RRESP[0], REQ_ADDR[2:0]};

`ifdef PTW_LAST_PTE_CACHE_EN
  logic                  cache_valid;
  logic [ADDR_WIDTH-4:0] cache_tag;
  logic [DATA_WIDTH-1:0] cache_data;

  assign cache_hit = cache_valid && (cache_tag == REQ_ADDR[ADDR_WIDTH-1:3]);

  // The response cycle fills the entry with a good PTE and clears it on an
  // error. A FLUSH, whenever it comes, clears it as well.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH)
      cache_valid <= 1'b0;
    else if (state == RESP)
      cache_valid <= ~RESP_ERR;
  end

  // NOTE: tag/data are left unreset; cache_valid alone decides whether they are used.
  always_ff @(posedge CLK) begin
    if (state == RESP && !FLUSH && !RESP_ERR) begin
      cache_tag  <= ARADDR[ADDR_WIDTH-1:3];
      cache_data <= RESP_DATA;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // NOTE: state and outputs use <= so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      drop       <= 1'b0;
      resp_pulse <= 1'b0;
      ARVALID    <= 1'b0;
      ARADDR     <= '0;
      RREADY     <= 1'b0;
      RESP_DATA  <= '0;
      RESP_ERR   <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      resp_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // A FLUSH in the same cycle wins over a new request.
          if (REQ_VALID && !FLUSH) begin
            if (cache_hit) begin
`ifdef PTW_LAST_PTE_CACHE_EN
              RESP_DATA  <= cache_data;
`endif
              RESP_ERR   <= 1'b0;
              resp_pulse <= 1'b1;
            end else begin
              ARADDR  <= {REQ_ADDR[ADDR_WIDTH-1:3], 3'b000};
              ARVALID <= 1'b1;
              BUSY    <= 1'b1;
              drop    <= 1'b0;
              state   <= ADDR;
            end
          end
        end

        // ARVALID may not be withdrawn once raised, so a FLUSH here only marks the walk as dropped.
        ADDR: begin
          if (FLUSH)
            drop <= 1'b1;
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
          end
        end

        DATA: begin
          if (RVALID) begin
            RREADY <= 1'b0;
            if (drop || FLUSH) begin
              // Leave RESP_DATA alone so it keeps the last delivered PTE.
              drop  <= 1'b0;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              RESP_DATA  <= RRESP[1] ? '0 : RDATA;
              RESP_ERR   <= RRESP[1];
              resp_pulse <= 1'b1;
              state      <= RESP;
            end
          end else if (FLUSH) begin
            drop <= 1'b1;
          end
        end

        RESP: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_axi_reader.sv
// Self-checking bench for ptw_axi_reader.
// The bench plays the AXI slave. A small transaction-level model predicts
// each walk's outcome:
//   - whether the AR and R handshakes happen,
//   - whether a response arrives, and its data, error flag and latency,
//   - what the last-PTE cache holds when PTW_LAST_PTE_CACHE_EN is defined.
module tb_ptw_axi_reader;
  localparam int         AW = 64;
  localparam int         DW = 64;
  localparam logic [3:0] ID = 4'd5;
`ifdef PTW_LAST_PTE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          CLK, RST, REQ_VALID, FLUSH;
  logic [AW-1:0] REQ_ADDR, ARADDR;
  logic          RESP_VALID, RESP_ERR, BUSY;
  logic [DW-1:0] RESP_DATA, RDATA;
  logic          ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [3:0]    ARID, RID;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST, RRESP;

  ptw_axi_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID(5)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .FLUSH(FLUSH),
    .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR), .BUSY(BUSY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RID(RID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec, n_err;

  // Reference model: cache contents and last delivered PTE.
  bit          m_valid;
  logic [60:0] m_tag;
  logic [63:0] m_data;
  logic [63:0] m_last_data;

  // Observations of the most recent walk.
  int          obs_ar_hs, obs_r_hs, obs_resp_cnt, obs_resp_cyc, obs_r_hs_cyc;
  int          obs_arv_cyc, obs_ar_bad, obs_busy_cyc;
  logic [63:0] obs_araddr, obs_resp_data;
  logic        obs_resp_err;
  bit          obs_supp_bad;

  function automatic bit model_hit(input logic [63:0] addr);
    return CACHE_EN && m_valid && (m_tag == addr[63:3]);
  endfunction

  // One walk: drive the request, act as the AXI slave, observe, and compare.
  task automatic run_txn(input string name, input logic [63:0] addr, input logic [63:0] data,
                         input logic err, input int ar_delay, input int r_delay,
                         input int flush_at, input int req2_at, input bit flush_on_resp);
    bit          ignored, hit, r_pending, flush_next;
    int          exp_ar, exp_resp, exp_lat, r_wait, span;
    logic [63:0] exp_addr, exp_data;
    logic        exp_err;
    ignored  = (flush_at == 0);
    hit      = model_hit(addr) && !ignored;
    exp_ar   = (!ignored && !hit) ? 1 : 0;
    exp_resp = (!ignored && (hit || flush_at < 0)) ? 1 : 0;
    exp_addr = {addr[63:3], 3'b000};
    exp_data = hit ? m_data : (err ? 64'd0 : data);
    exp_err  = hit ? 1'b0 : err;
    obs_ar_hs = 0; obs_r_hs = 0; obs_resp_cnt = 0; obs_resp_cyc = -1; obs_r_hs_cyc = -1;
    obs_arv_cyc = 0; obs_ar_bad = 0; obs_busy_cyc = 0; obs_araddr = '0;
    obs_resp_data = '0; obs_resp_err = 1'b0; obs_supp_bad = 1'b0;
    r_pending = 1'b0; r_wait = 0;

    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = addr; FLUSH = ignored;
    span = ar_delay + r_delay + 8;
    for (int cyc = 1; cyc <= span; cyc++) begin
      @(negedge CLK);
      flush_next = (cyc == flush_at);
      if (BUSY === 1'b1) obs_busy_cyc++;
      if (ARVALID === 1'b1) begin
        obs_arv_cyc++;
        obs_araddr = ARADDR;
        if (ARADDR !== exp_addr || ARLEN !== 8'd0 || ARSIZE !== 3'd3 ||
            ARBURST !== 2'b01 || ARID !== ID)
          obs_ar_bad++;
      end
      if (RESP_VALID === 1'b1) begin
        obs_resp_cnt++;
        obs_resp_cyc  = cyc;
        obs_resp_data = RESP_DATA;
        obs_resp_err  = RESP_ERR;
        if (flush_on_resp) begin
          FLUSH = 1'b1;
          #1;
          if (RESP_VALID !== 1'b0) obs_supp_bad = 1'b1;
          flush_next = 1'b1;
        end
      end
      // Inputs for the next rising edge.
      REQ_VALID = (cyc == req2_at);
      REQ_ADDR  = (cyc == req2_at) ? (addr ^ 64'h0000_0000_0040_0000) : addr;
      FLUSH     = flush_next;
      if (r_pending) begin
        if (r_wait >= r_delay) RVALID = 1'b1;
        r_wait++;
      end else begin
        RVALID = 1'b0;
      end
      RDATA   = RVALID ? data : {$urandom, $urandom};
      RRESP   = RVALID ? (err ? 2'b10 : 2'b00) : 2'b11;
      RLAST   = RVALID;
      RID     = RVALID ? ID : 4'd0;
      ARREADY = (ARVALID === 1'b1) && (obs_arv_cyc > ar_delay);
      // Registered DUT outputs are stable until the edge, so these handshakes will fire.
      if (ARVALID === 1'b1 && ARREADY) begin
        obs_ar_hs++;
        r_pending = 1'b1;
        r_wait    = 0;
      end
      if (RVALID && RREADY === 1'b1) begin
        obs_r_hs++;
        obs_r_hs_cyc = cyc;
        r_pending    = 1'b0;
      end
    end
    REQ_VALID = 1'b0; FLUSH = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;

    n_vec++;
    if (obs_ar_hs !== exp_ar) begin
      n_err++; $display("FAIL %s ar_handshakes: got %0d want %0d", name, obs_ar_hs, exp_ar);
    end
    n_vec++;
    if (obs_r_hs !== exp_ar) begin
      n_err++; $display("FAIL %s r_handshakes: got %0d want %0d", name, obs_r_hs, exp_ar);
    end
    n_vec++;
    if (obs_resp_cnt !== exp_resp) begin
      n_err++; $display("FAIL %s resp_pulses: got %0d want %0d", name, obs_resp_cnt, exp_resp);
    end
    n_vec++;
    if (obs_ar_bad !== 0) begin
      n_err++; $display("FAIL %s ar_fields: %0d bad cycles, want 0", name, obs_ar_bad);
    end
    n_vec++;
    if (obs_arv_cyc !== exp_ar * (ar_delay + 1)) begin
      n_err++; $display("FAIL %s arvalid_cycles: got %0d want %0d", name, obs_arv_cyc, exp_ar * (ar_delay + 1));
    end
    if (exp_resp == 1) begin
      exp_lat = hit ? 1 : obs_r_hs_cyc + 1;
      n_vec++;
      if (obs_resp_data !== exp_data || obs_resp_err !== exp_err) begin
        n_err++; $display("FAIL %s resp_payload: got %h/%b want %h/%b", name, obs_resp_data, obs_resp_err, exp_data, exp_err);
      end
      n_vec++;
      if (obs_resp_cyc !== exp_lat) begin
        n_err++; $display("FAIL %s resp_cycle: got %0d want %0d", name, obs_resp_cyc, exp_lat);
      end
      m_last_data = exp_data;
    end
    n_vec++;
    if ((obs_busy_cyc != 0) !== (exp_ar == 1)) begin
      n_err++; $display("FAIL %s busy_seen: got %0d cycles, want nonzero=%0d", name, obs_busy_cyc, exp_ar);
    end
    n_vec++;
    if (BUSY !== 1'b0 || ARVALID !== 1'b0 || RREADY !== 1'b0) begin
      n_err++; $display("FAIL %s idle_after: busy=%b arvalid=%b rready=%b want 0", name, BUSY, ARVALID, RREADY);
    end
    n_vec++;
    if (RESP_DATA !== m_last_data) begin
      n_err++; $display("FAIL %s resp_data_hold: got %h want %h", name, RESP_DATA, m_last_data);
    end
    if (flush_on_resp) begin
      n_vec++;
      if (obs_supp_bad) begin
        n_err++; $display("FAIL %s flush_in_resp: RESP_VALID got 1 want 0", name);
      end
    end

    // Cache model update.
    if (flush_at >= 0 || flush_on_resp) m_valid = 1'b0;
    else if (!hit) begin
      if (err) m_valid = 1'b0;
      else begin
        m_valid = 1'b1; m_tag = addr[63:3]; m_data = data;
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_vec++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b0 || RESP_VALID !== 1'b0 || RESP_ERR !== 1'b0 ||
        BUSY !== 1'b0 || RESP_DATA !== 64'd0 || ARADDR !== 64'd0) begin
      n_err++;
      $display("FAIL %s: arv=%b rr=%b rv=%b re=%b busy=%b rd=%h ara=%h want all 0",
               name, ARVALID, RREADY, RESP_VALID, RESP_ERR, BUSY, RESP_DATA, ARADDR);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    RST = 1'b0;
    m_valid = 1'b0; m_last_data = '0;
  endtask

  task automatic test_basic;
    run_txn("basic", 64'h0000_0000_8000_1004, 64'h0000_0000_2000_00CF, 1'b0, 0, 0, -1, -1, 1'b0);
    n_vec++;
    if (obs_araddr !== 64'h0000_0000_8000_1000) begin
      n_err++; $display("FAIL basic araddr: got %h want 0000000080001000", obs_araddr);
    end
  endtask

  task automatic test_ar_stall;
    run_txn("ar_stall", 64'h0000_0000_8000_2008, 64'h1234_5678_9ABC_DEF0, 1'b0, 5, 1, -1, -1, 1'b0);
    n_vec++;
    if (obs_arv_cyc !== 6) begin
      n_err++; $display("FAIL ar_stall arvalid_len: got %0d want 6", obs_arv_cyc);
    end
  endtask

  task automatic test_error;
    run_txn("error", 64'h0000_0000_8000_3000, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1, 2, -1, -1, 1'b0);
  endtask

  task automatic test_flush_addr;
    run_txn("flush_addr", 64'h0000_0000_8000_5000, 64'h0000_0000_3000_00CF, 1'b0, 3, 0, 1, -1, 1'b0);
  endtask

  task automatic test_flush_with_req;
    run_txn("flush_with_req", 64'h0000_0000_8000_6000, 64'h0000_0000_4000_00CF, 1'b0, 0, 0, 0, -1, 1'b0);
  endtask

  task automatic test_busy_ignore;
    run_txn("busy_ignore", 64'h0000_0000_8000_7018, 64'h0000_0000_5000_00CF, 1'b0, 3, 1, -1, 2, 1'b0);
  endtask

  task automatic test_flush_in_resp;
    run_txn("flush_in_resp", 64'h0000_0000_8000_8010, 64'h0000_0000_6000_00CF, 1'b0, 0, 0, -1, -1, 1'b1);
    run_txn("after_resp_flush", 64'h0000_0000_8000_8010, 64'h0000_0000_6000_00CF, 1'b0, 0, 0, -1, -1, 1'b0);
    n_vec++;
    if (obs_ar_hs !== 1) begin
      n_err++; $display("FAIL after_resp_flush refetch: got %0d AR want 1", obs_ar_hs);
    end
  endtask

  task automatic test_cache_repeat;
    run_txn("cache_fill", 64'h0000_0000_8000_1000, 64'h0000_0000_2000_00CF, 1'b0, 0, 0, -1, -1, 1'b0);
    run_txn("cache_repeat", 64'h0000_0000_8000_1000, 64'h0000_0000_7777_00CF, 1'b0, 0, 0, -1, -1, 1'b0);
    n_vec++;
    if (obs_ar_hs !== (CACHE_EN ? 0 : 1)) begin
      n_err++; $display("FAIL cache_repeat ar_count: got %0d want %0d", obs_ar_hs, CACHE_EN ? 0 : 1);
    end
    @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    m_valid = 1'b0;
    n_vec++;
    if (BUSY !== 1'b0 || RESP_VALID !== 1'b0) begin
      n_err++; $display("FAIL idle_flush: busy=%b resp_valid=%b want 0", BUSY, RESP_VALID);
    end
    run_txn("cache_after_flush", 64'h0000_0000_8000_1000, 64'h0000_0000_2000_00CF, 1'b0, 0, 0, -1, -1, 1'b0);
    n_vec++;
    if (obs_ar_hs !== 1) begin
      n_err++; $display("FAIL cache_after_flush ar_count: got %0d want 1", obs_ar_hs);
    end
  endtask

  task automatic test_random;
    logic [63:0] addr, data;
    logic        err;
    int          ad, rd, fa;
    for (int i = 0; i < 24; i++) begin
      addr = 64'h0000_0000_8000_0000 + (64'($urandom_range(0, 3)) << 12) + 64'($urandom_range(0, 7));
      data = {$urandom, $urandom};
      err  = ($urandom_range(0, 5) == 0);
      ad   = int'($urandom_range(0, 4));
      rd   = int'($urandom_range(0, 3));
      fa   = -1;
      if (!model_hit(addr) && $urandom_range(0, 4) == 0)
        fa = int'($urandom_range(1, ad + rd + 2));
      run_txn($sformatf("rand%0d", i), addr, data, err, ad, rd, fa, -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_ADDR = 64'h0000_0000_8000_9000;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    n_vec++;
    if (ARVALID !== 1'b1) begin
      n_err++; $display("FAIL reset_mid pre: arvalid got %b want 1", ARVALID);
    end
    RST = 1'b1;
    @(negedge CLK);
    check_idle_outputs("reset_mid");
    RST = 1'b0;
    m_valid = 1'b0; m_last_data = '0;
    run_txn("post_reset", 64'h0000_0000_8000_9008, 64'h0000_0000_0BAD_F00D, 1'b0, 2, 1, -1, -1, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    RST = 1'b1; REQ_VALID = 1'b0; REQ_ADDR = '0; FLUSH = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RID = 4'd0;
    m_valid = 1'b0; m_tag = '0; m_data = '0; m_last_data = '0;
    test_reset;
    test_basic;
    test_ar_stall;
    test_error;
    test_flush_addr;
    test_flush_with_req;
    test_busy_ignore;
    test_flush_in_resp;
    test_cache_repeat;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
